// File: rtl/countdown16_sched_if.sv
// Request/grant bundle between N requesters and the shared countdown timer.
// The master side drives the requests and load values; the slave side
// (the scheduler) returns the grant, done, busy and count views.
interface countdown16_sched_if #(
    parameter int N = 4
);
    logic [N-1:0]    req;
    logic [16*N-1:0] load_val;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [15:0]     count;

    modport master (
        output req,
        output load_val,
        input  grant,
        input  done,
        input  busy,
        input  count
    );

    modport slave (
        input  req,
        input  load_val,
        output grant,
        output done,
        output busy,
        output count
    );
endinterface

// File: rtl/countdown16_rr_scheduler.sv
// countdown16_rr_scheduler
// Shares one 16-bit down counter between N requesters. A round-robin arbiter
// picks a requester, loads its count value, counts down to zero and pulses
// done to the winner for one cycle. All state changes on the falling edge
// of clock0; reset is asynchronous and active-low.
//
// Optional feature: define COUNTDOWN16_SCHED_PAUSE_EN to add a pause input
// that freezes the running countdown (abandon through req still works).
module countdown16_rr_scheduler #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic               clock0,
    input  logic               reset,
`ifdef COUNTDOWN16_SCHED_PAUSE_EN
    input  logic               pause,
`endif
    countdown16_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     count_q, count_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    done_q,  done_d;
    logic [PW-1:0]   ptr_q,   ptr_d;
    logic [PW-1:0]   win_q,   win_d;

    logic [15:0]     lv [N];
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [PW-1:0]   win_inc;
    logic            run_hold;

    // Per-requester view of the packed load value bus.
    for (genvar g = 0; g < N; g++) begin : g_lv
        assign lv[g] = bus.load_val[16*g +: 16];
    end

    // Pointer just past the current winner, wrapping at N (N need not be a power of two).
    assign win_inc = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);

`ifdef COUNTDOWN16_SCHED_PAUSE_EN
    assign run_hold = pause;
`else
    assign run_hold = 1'b0;
`endif

    // Round-robin scan: first asserted request starting at ptr and wrapping modulo N.
    always_comb begin : arb_scan
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!pick_vld && bus.req[PW'(idx)]) begin
                pick_vld = 1'b1;
                pick     = PW'(idx);
            end
        end
    end

    // Next-state and output logic; done defaults low so it is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        grant_d = grant_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_RUN;
                    win_d   = pick;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
                    count_d = lv[pick];
                end
            end
            S_RUN: begin
                if (!bus.req[win_q]) begin
                    // Abandon wins over everything, including pause and zero.
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = win_inc;
                end else if (!run_hold) begin
                    if (count_q == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = grant_q;
                    end else begin
                        count_d = count_q - 16'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = win_inc;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers, updated on the falling edge with asynchronous active-low reset.
    always_ff @(negedge clock0 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= 16'hFFFF;
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.count = count_q;

endmodule
